// File: rtl/adder_pipelined_pkg.sv
// Shared ALU definitions for the pipelined adder: op encodings, slice sizing
// and the parameter legality check used at elaboration.
package adder_pipelined_pkg;

    typedef enum logic [0:0] {
        ALU_OP_ADD = 1'b0,
        ALU_OP_SUB = 1'b1
    } alu_op_e;

    localparam alu_op_e ALU_SUB_SELECT = ALU_OP_SUB;

    function automatic int calcSlice(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit sliceFits(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipelined_slice.sv
// One pipeline slice: a ripple of full_adder cells feeding the registered
// partial sum, carry, carry-into-MSB and valid bit of that stage.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module adder_slice_stage #(
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout,
    output logic             o_msbCin
);
    logic [SLICE:0]   w_carry;
    logic [SLICE-1:0] w_sum;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (w_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    // Bubbles shift like real beats; only the enable (global advance) can hold the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_sum    <= '0;
            o_cout   <= 1'b0;
            o_msbCin <= 1'b0;
        end else if (i_en) begin
            o_valid  <= i_valid;
            o_sum    <= w_sum;
            o_cout   <= w_carry[SLICE];
            o_msbCin <= w_carry[SLICE-1];
        end
    end

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined add/subtract unit: WIDTH bits split over STAGES registered carry
// slices, with a valid/ready handshake and back-pressure on both sides.
module adder_pipelined
    import adder_pipelined_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int SLICE = calcSlice(WIDTH, STAGES);

    if (!sliceFits(WIDTH, STAGES)) begin : g_badParams
        $error("adder_pipelined: WIDTH must be a multiple of STAGES and STAGES <= WIDTH");
    end

    logic              w_adv;
    alu_op_e           w_op;
    logic [WIDTH-1:0]  w_bCond;
    logic              w_seed;
    logic [WIDTH-1:0]  w_aIn  [STAGES];
    logic [WIDTH-1:0]  w_bIn  [STAGES];
    logic [WIDTH-1:0]  w_res  [STAGES];
    logic [SLICE-1:0]  w_sliceSum [STAGES];
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_carry;
    logic [STAGES-1:0] w_msbCin;
    logic              w_unusedOps;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_op    = sub ? ALU_OP_SUB : ALU_OP_ADD;
    assign w_bCond = (w_op == ALU_SUB_SELECT) ? ~b : b;
    assign w_seed  = (w_op == ALU_SUB_SELECT) ? 1'b1 : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic w_cinStage;
        logic w_vinStage;

        if (k == 0) begin : g_head
            assign w_aIn[0]   = a;
            assign w_bIn[0]   = w_bCond;
            assign w_cinStage = w_seed;
            assign w_vinStage = in_valid;
            assign w_res[0]   = WIDTH'(w_sliceSum[0]);
        end else begin : g_body
            logic [WIDTH-1:0] r_aHold;
            logic [WIDTH-1:0] r_bHold;
            logic [WIDTH-1:0] r_lowHold;

            // Skew registers: operands travel alongside the beat, lower result bits follow it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_aHold   <= '0;
                    r_bHold   <= '0;
                    r_lowHold <= '0;
                end else if (w_adv) begin
                    r_aHold   <= w_aIn[k-1];
                    r_bHold   <= w_bIn[k-1];
                    r_lowHold <= w_res[k-1];
                end
            end

            assign w_aIn[k]   = r_aHold;
            assign w_bIn[k]   = r_bHold;
            assign w_cinStage = w_carry[k-1];
            assign w_vinStage = w_valid[k-1];
            assign w_res[k]   = r_lowHold | (WIDTH'(w_sliceSum[k]) << (k * SLICE));
        end

        adder_slice_stage #(
            .SLICE (SLICE)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (w_adv),
            .i_valid  (w_vinStage),
            .i_a      (w_aIn[k][k*SLICE +: SLICE]),
            .i_b      (w_bIn[k][k*SLICE +: SLICE]),
            .i_cin    (w_cinStage),
            .o_valid  (w_valid[k]),
            .o_sum    (w_sliceSum[k]),
            .o_cout   (w_carry[k]),
            .o_msbCin (w_msbCin[k])
        );
    end

    // The last stage only consumes its own operand slice; inner MSB carries feed nothing.
    assign w_unusedOps = ^{w_aIn[STAGES-1], w_bIn[STAGES-1], w_msbCin};

    assign out_valid = w_valid[STAGES-1];
    assign sum       = w_res[STAGES-1];
    assign c_out     = w_carry[STAGES-1];
    assign overflow  = w_msbCin[STAGES-1] ^ w_carry[STAGES-1];

endmodule
